// File: rtl/ws2812_rx.sv
// Purpose: WS2812 serial receiver; decodes G,R,B bit stream into {R,G,B} pixels, frame_done/err pulses.
// Latency: ws_in passes a 2-flop synchronizer; pixel_valid rises 1 cycle after the decoding falling edge.
// Backpressure: none; pixel_valid/frame_done/err are single-cycle pulses the consumer must take.
// Option: define WS2812_RX_FWD_EN to forward the stream on ws_out once this node's pixel is taken.
module ws2812_rx #(
  parameter int T_GLITCH = 8,
  parameter int T_THRESH = 60,
  parameter int T_HMAX   = 150,
  parameter int T_RESET  = 5000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        ws_in,
  output logic [23:0] pixel_data,
  output logic [6:0]  pixel_idx,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic        err,
  output logic        ws_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  localparam logic [16:0] GLITCH_L = 17'(T_GLITCH);
  localparam logic [16:0] THRESH_L = 17'(T_THRESH);
  localparam logic [16:0] HMAX_L   = 17'(T_HMAX);
  localparam logic [16:0] RESET_L  = 17'(T_RESET);

  logic        s_meta;
  logic        s_sync;
  logic        s_prev;
  logic        rise;
  logic        fall;
  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [16:0] len;
  logic        bit_ev;
  logic        bit_val;
  logic        glitch_ev;
  logic        hmax_ev;
  logic        end_ev;
  logic [22:0] shreg;
  logic [23:0] word;
  logic [4:0]  bit_cnt;
  logic [6:0]  idx_nxt;
  logic        px_any;

  assign rise = s_sync & ~s_prev;
  assign fall = ~s_sync & s_prev;
  // The counter is cleared on entry, one cycle after the edge that caused the
  // transition, so the number of elapsed cycles in the current level is cnt+1.
  assign len  = {1'b0, cnt} + 17'd1;
  assign word = {shreg, bit_val};

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s_meta <= ws_in;
      s_sync <= s_meta;
      s_prev <= s_sync;
    end
  end

  // State register and saturating level-length counter, cleared on every state change
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  // Next state and bit/error/frame-end decisions
  always_comb begin
    state_nxt = state;
    bit_ev    = 1'b0;
    bit_val   = 1'b0;
    glitch_ev = 1'b0;
    hmax_ev   = 1'b0;
    end_ev    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_nxt = HIGH;
      end
      HIGH: begin
        // Over-long check comes first so a pulse of T_HMAX+1 is an error even
        // when its falling edge lands in the same cycle.
        if (len > HMAX_L) begin
          hmax_ev   = 1'b1;
          state_nxt = IDLE;
        end else if (fall) begin
          state_nxt = LOW;
          if (len < GLITCH_L) begin
            glitch_ev = 1'b1;
          end else begin
            bit_ev  = 1'b1;
            bit_val = (len >= THRESH_L);
          end
        end
      end
      LOW: begin
        // A low of exactly T_RESET still ends the frame; if the next frame's
        // first rising edge arrives in that cycle it is not lost.
        if (len == RESET_L) begin
          end_ev    = 1'b1;
          state_nxt = rise ? HIGH : IDLE;
        end else if (rise) begin
          state_nxt = HIGH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit assembly, pixel output, frame bookkeeping and output pulses
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      idx_nxt     <= '0;
      px_any      <= 1'b0;
      pixel_data  <= '0;
      pixel_idx   <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      if (glitch_ev || hmax_ev) err <= 1'b1;
      if (hmax_ev) bit_cnt <= '0;
      if (bit_ev) begin
        shreg <= word[22:0];
        if (bit_cnt == 5'd23) begin
          // Wire order is G,R,B; present as {R,G,B}
          pixel_data  <= {word[15:8], word[23:16], word[7:0]};
          pixel_valid <= 1'b1;
          pixel_idx   <= idx_nxt;
          idx_nxt     <= idx_nxt + 7'd1;
          px_any      <= 1'b1;
          bit_cnt     <= '0;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
      if (end_ev) begin
        if (px_any || (bit_cnt != 5'd0)) frame_done <= 1'b1;
        if (bit_cnt != 5'd0) err <= 1'b1;
        bit_cnt   <= '0;
        idx_nxt   <= '0;
        pixel_idx <= '0;
        px_any    <= 1'b0;
      end
    end
  end

`ifdef WS2812_RX_FWD_EN
  logic fwd_on;

  // Forward the synchronized stream once this node has taken its pixel, until frame end
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      fwd_on <= 1'b0;
      ws_out <= 1'b0;
    end else begin
      ws_out <= fwd_on & s_sync;
      if (end_ev) begin
        fwd_on <= 1'b0;
      end else if (bit_ev && (bit_cnt == 5'd23)) begin
        fwd_on <= 1'b1;
      end
    end
  end
`else
  assign ws_out = 1'b0;
`endif

endmodule
